tone_period_meter: RTL and testbench
====================================

// Module: tone_period_meter
// PURPOSE
//  Measures the period and high time of a slow square wave (divided clock or
//  piano tone output) in clk_in cycles. Closes the loop on the clock-divider
//  chain: dividers generate tones, and this block checks what they produce.
//  Feeds note-verification and display logic with one-cycle result pulses.
// PARAMETERS
//  CNT_W       27           counter/result width in bits
//  TIMEOUT     100_000_000  cycles with no rising edge before signal_lost (1 s @100 MHz)
//  MIN_PERIOD  4            shortest accepted period; shorter edges are glitches
// PORTS
//  clk_in        in   1      single system clock; all logic on posedge
//  rst_n         in   1      asynchronous, active-low reset
//  sig_in        in   1      square wave under test; asynchronous to clk_in
//  period_out    out  CNT_W  last accepted period, rising edge to rising edge
//  high_out      out  CNT_W  synced-high cycles within that period
//  period_valid  out  1      one-cycle pulse when period_out/high_out update
//  signal_lost   out  1      level; high while in LOST state
// BEHAVIOUR
//  - Reset (async assert, sync release): sync flops=0, period_out=0, high_out=0,
//    period_valid=0, signal_lost=0, cnt=0, hcnt=0, state=ACQUIRE.
//  - sig_in passes through a 2-flop synchronizer, then an edge register.
//    rise = s_sync & ~s_prev. Latency from sig_in rising to period_valid:
//    3 clk_in cycles when setup is met.
//  - FSM:
//    ACQUIRE: wait for rise -> MEASURE with cnt=0, hcnt=0. No valid pulse.
//    MEASURE: cnt+=1 each cycle; hcnt+=1 when s_sync=1.
//      On rise with cnt+1 >= MIN_PERIOD: period_out<=cnt+1,
//        high_out<=hcnt (+1 if s_sync was high that cycle), period_valid=1,
//        cnt<=0, hcnt<=0.
//      On rise with cnt+1 < MIN_PERIOD: edge ignored, counting continues,
//        no pulse.
//      When cnt==TIMEOUT-1 with no accepted rise: -> LOST.
//    LOST: signal_lost=1. cnt/hcnt frozen. period_out/high_out hold their
//      last value. On rise: -> MEASURE, cnt=0, hcnt=0, signal_lost<=0,
//      no valid pulse; a partial period is never reported.
//  - Timeout has priority over rise in the same cycle: state goes to LOST,
//    and the next rise restarts measurement.
//  - Counters never wrap: TIMEOUT <= 2**CNT_W-1 is an elaboration check;
//    hcnt <= cnt always.
//  - period_valid is never high for two consecutive cycles (MIN_PERIOD >= 2).
//  - rst_n asserted mid-period discards the partial count. The first
//    post-reset rise only arms the block (ACQUIRE).
// STRUCTURE
//  - Shared header piano_defs.vh: FSM state codes (ACQUIRE=2'd0,
//    MEASURE=2'd1, LOST=2'd2) and the default CNT_W, shared with the dividers.
//  - Sub-module sync_edge_detect: 2-flop synchronizer plus edge register,
//    outputs s_sync and rise; reusable for the key inputs.
//  - Top level: FSM, cnt/hcnt counters, output registers.
// TESTING
//  1 sig_in toggles every 2 clk_in (divide-by-4) -> after arming,
//    period_valid every 4 cycles with period_out=4, high_out=2.
//  2 sig_in high 3 / low 7 cycles -> period_out=10, high_out=3 each pulse;
//    first rise after reset gives no pulse.
//  3 1-cycle glitch inside a 10-cycle period (MIN_PERIOD=4) -> no extra pulse;
//    next pulse period_out=10.
//  4 TIMEOUT=50, sig_in stuck low after a valid period -> signal_lost=1 at
//    cycle 50; period_out holds; a new square wave clears signal_lost; first
//    pulse comes one full period after the restart edge.
//  5 rst_n low mid-period for 1 cycle -> outputs 0 immediately (async);
//    re-arms on the next rise; the second rise reports the correct period.
//  6 Random period 4..1000 with random phase vs clk_in -> each period_out
//    within +/-1 of nominal; period_valid never on back-to-back cycles.

Source files
------------

// File: rtl/tone_period_meter_pkg.sv
// tone_period_meter_pkg: FSM state codes and default counter width shared with the divider chain
package tone_period_meter_pkg;
  localparam int CNT_W_DEF = 27;
  typedef enum logic [1:0] {ACQUIRE = 2'd0, MEASURE = 2'd1, LOST = 2'd2} state_t;
endpackage

// File: rtl/tone_period_meter_sync_edge_detect.sv
// tone_period_meter_sync_edge_detect: 2-flop synchronizer plus edge register giving s_sync and rise
module tone_period_meter_sync_edge_detect (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic s_sync,
  output logic rise
);
  logic meta, s_prev;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      meta   <= 1'b0;
      s_sync <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      meta   <= sig_in;
      s_sync <= meta;
      s_prev <= s_sync;
    end
  assign rise = s_sync & ~s_prev;
endmodule

// File: rtl/tone_period_meter.sv
// tone_period_meter: measures period and high time of a slow square wave in clk_in cycles
module tone_period_meter
  import tone_period_meter_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIMEOUT    = 100_000_000,
  parameter int MIN_PERIOD = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             signal_lost
);
  if (longint'(TIMEOUT) > (longint'(1) << CNT_W) - 1) begin : g_timeout_chk
    $error("TIMEOUT does not fit in CNT_W bits");
  end
  if (MIN_PERIOD < 2) begin : g_min_chk
    $error("MIN_PERIOD must be at least 2");
  end
  state_t state, state_nxt;
  logic s_sync, rise, timeout, accept, restart;
  logic [CNT_W-1:0] cnt, hcnt, cnt_inc, hcnt_inc;
  tone_period_meter_sync_edge_detect u_sync (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .s_sync(s_sync),
    .rise  (rise)
  );
  assign cnt_inc  = cnt + CNT_W'(1);
  assign hcnt_inc = hcnt + CNT_W'(s_sync);
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) state <= ACQUIRE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == MEASURE ? (timeout ? LOST : MEASURE)
              : rise ? MEASURE
              : state == LOST ? LOST : ACQUIRE;
  // timeout outranks a coincident rise, so that edge never reports a period
  always_comb begin
    timeout     = state == MEASURE && cnt == CNT_W'(TIMEOUT - 1);
    accept      = state == MEASURE && !timeout && rise && cnt_inc >= CNT_W'(MIN_PERIOD);
    restart     = state != MEASURE && rise;
    signal_lost = state == LOST;
  end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      cnt          <= '0;
      hcnt         <= '0;
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= accept;
      if (accept) begin
        period_out <= cnt_inc;
        high_out   <= hcnt_inc;
      end
      if (restart || accept) begin
        cnt  <= '0;
        hcnt <= '0;
      end else if (state == MEASURE && !timeout) begin
        cnt  <= cnt_inc;
        hcnt <= hcnt_inc;
      end
    end
endmodule

// File: tb/tb_tone_period_meter.sv
// tb_tone_period_meter: scoreboard bench; stimulus queues expected periods, monitor checks each valid pulse
module tb_tone_period_meter;
  localparam int CW = 27;
  localparam int TO = 1100;
  localparam int MP = 4;
  typedef struct {int p; int h; bit tol;} exp_t;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic sig_in = 1'b0;
  logic [CW-1:0] period_out, high_out;
  logic period_valid, signal_lost;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  bit prev_v = 1'b0;
  always #5 clk_in = ~clk_in;
  tone_period_meter #(.CNT_W(CW), .TIMEOUT(TO), .MIN_PERIOD(MP)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .sig_in      (sig_in),
    .period_out  (period_out),
    .high_out    (high_out),
    .period_valid(period_valid),
    .signal_lost (signal_lost)
  );
  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic check_tol(string name, longint act, longint exp);
    checks++;
    if (act - exp > 1 || exp - act > 1) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d+-1", name, act, exp);
    end
  endtask
  task automatic push(int p, int h, bit tol);
    exp_t x;
    x.p = p;
    x.h = h;
    x.tol = tol;
    q.push_back(x);
  endtask
  task automatic seg(bit lv, int n);
    sig_in = lv;
    repeat (n) @(negedge clk_in);
  endtask
  task automatic wave(int h, int l, int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) push(h + l, h, 1'b0);
      seg(1'b1, h);
      seg(1'b0, l);
    end
  endtask
  task automatic do_reset();
    sig_in = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    check("rst_period", period_out, 0);
    check("rst_high", high_out, 0);
    check("rst_valid", period_valid, 0);
    check("rst_lost", signal_lost, 0);
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask
  task automatic drain(string name);
    int k = 0;
    while (q.size() != 0 && k < 30) begin
      @(negedge clk_in);
      k++;
    end
    check(name, q.size(), 0);
  endtask
  function automatic int jit();
    int j = $urandom_range(0, 7);
    return j >= 5 ? j + 1 : j;
  endfunction
  always @(negedge clk_in) begin
    if (period_valid) begin
      check("valid_back_to_back", prev_v, 0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid period=%0d high=%0d expected=none", period_out, high_out);
      end else begin
        e = q.pop_front();
        if (e.tol) begin
          check_tol("period_rand", period_out, e.p);
          check_tol("high_rand", high_out, e.h);
        end else begin
          check("period", period_out, e.p);
          check("high", high_out, e.h);
        end
      end
    end
    prev_v = period_valid;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lost_at, p, h, pp, ph;
    do_reset();
    wave(2, 2, 7);
    drain("div4_drain");
    do_reset();
    wave(3, 7, 5);
    drain("h3l7_drain");
    do_reset();
    seg(1'b1, 3); seg(1'b0, 7);
    push(10, 3, 1'b0);
    seg(1'b1, 1); seg(1'b0, 1); seg(1'b1, 1); seg(1'b0, 7);
    push(10, 2, 1'b0);
    seg(1'b1, 3); seg(1'b0, 7);
    push(10, 3, 1'b0);
    seg(1'b1, 3); seg(1'b0, 5);
    drain("glitch_drain");
    do_reset();
    seg(1'b1, 5); seg(1'b0, 5);
    push(10, 5, 1'b0);
    sig_in = 1'b1;
    lost_at = 0;
    for (int i = 1; i <= TO + 50 && lost_at == 0; i++) begin
      @(negedge clk_in);
      if (i == 5) sig_in = 1'b0;
      if (signal_lost) lost_at = i;
    end
    check("lost_cycle", lost_at, TO + 3);
    check("lost_hold_period", period_out, 10);
    check("lost_hold_high", high_out, 5);
    seg(1'b1, 5);
    check("lost_cleared", signal_lost, 0);
    seg(1'b0, 5);
    push(10, 5, 1'b0);
    seg(1'b1, 5); seg(1'b0, 5);
    drain("lost_drain");
    do_reset();
    seg(1'b1, 4); seg(1'b0, 6);
    push(10, 4, 1'b0);
    seg(1'b1, 4); seg(1'b0, 2);
    check("pre_rst_period", period_out, 10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_period", period_out, 0);
    check("mid_rst_high", high_out, 0);
    check("mid_rst_valid", period_valid, 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    seg(1'b0, 3);
    wave(4, 6, 3);
    drain("rst_drain");
    do_reset();
    pp = 0;
    ph = 0;
    for (int i = 0; i < 9; i++) begin
      p = $urandom_range(5, 1000);
      h = $urandom_range(2, p - 2);
      if (i > 0) push(pp, ph, 1'b1);
      #(jit());
      sig_in = 1'b1;
      repeat (h) @(negedge clk_in);
      #(jit());
      sig_in = 1'b0;
      repeat (p - h) @(negedge clk_in);
      pp = p;
      ph = h;
    end
    push(pp, ph, 1'b1);
    #(jit());
    sig_in = 1'b1;
    repeat (3) @(negedge clk_in);
    sig_in = 1'b0;
    drain("rand_drain");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
